// File: rtl/intra_pred_pkg.sv
// rtl/intra_pred_pkg.sv - shared mode codes and FSM state encodings for the intra scheduler
//
// Purpose: the prediction-mode codes, the number of modes and the one-hot
// state type used by intra_pred_sched and intra_mode_sel.
// Ports: none (package).
package intra_pred_pkg;

    localparam int MODE_NUM = 4;

    localparam int MODE_DC = 0;
    localparam int MODE_TM = 1;
    localparam int MODE_VE = 2;
    localparam int MODE_HE = 3;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_ISSUE = 6'b000010,
        ST_WAIT  = 6'b000100,
        ST_OUT   = 6'b001000,
        ST_NEXT  = 6'b010000,
        ST_FDONE = 6'b100000
    } state_t;

endpackage

// File: rtl/intra_pred_sched_if.sv
// rtl/intra_pred_sched_if.sv - frame control, predictor and result handshake bundle
//
// Purpose: groups every non-clock/reset signal of intra_pred_sched.
// Ports (signals):
//   start, mb_w, mb_h        frame request from the controller
//   pred_start, pred_x/y/mode, pred_done   predictor handshake
//   res_valid, res_ready     result handshake to downstream
//   busy, frame_done         status
// Modports: master = controller/bench side, slave = scheduler side.
interface intra_pred_sched_if #(
    parameter int BLOCK_NUM = 10,
    parameter int MODE_W    = 2
);
    logic                 start;
    logic [BLOCK_NUM-1:0] mb_w;
    logic [BLOCK_NUM-1:0] mb_h;
    logic                 pred_start;
    logic [BLOCK_NUM-1:0] pred_x;
    logic [BLOCK_NUM-1:0] pred_y;
    logic [MODE_W-1:0]    pred_mode;
    logic                 pred_done;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output start, mb_w, mb_h, pred_done, res_ready,
        input  pred_start, pred_x, pred_y, pred_mode, res_valid, busy, frame_done
    );

    modport slave (
        input  start, mb_w, mb_h, pred_done, res_ready,
        output pred_start, pred_x, pred_y, pred_mode, res_valid, busy, frame_done
    );
endinterface

// File: rtl/intra_mode_sel.sv
// rtl/intra_mode_sel.sv - combinational next-prediction-mode selector
//
// Purpose: picks the lowest enabled mode strictly above the current one.
// Optional feature macro: INTRA_MODE_SKIP_EN (skip modes whose neighbours
// are missing at the frame edge); without it every mode is enabled.
// Ports:
//   i_mode       current mode
//   i_x_zero     macroblock column is 0
//   i_y_zero     macroblock row is 0
//   o_next_mode  next enabled mode (DC when none remains)
//   o_last       no enabled mode above i_mode
module intra_mode_sel
    import intra_pred_pkg::*;
#(
    parameter int MODE_W = 2
) (
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_x_zero,
    input  logic              i_y_zero,
    output logic [MODE_W-1:0] o_next_mode,
    output logic              o_last
);

    logic [MODE_NUM-1:0] w_en;

`ifdef INTRA_MODE_SKIP_EN
    // TM needs both the left and top neighbours, VE the top, HE the left.
    assign w_en[MODE_DC] = 1'b1;
    assign w_en[MODE_TM] = !i_x_zero && !i_y_zero;
    assign w_en[MODE_VE] = !i_y_zero;
    assign w_en[MODE_HE] = !i_x_zero;
`else
    logic w_unused_zero;
    assign w_en          = '1;
    assign w_unused_zero = i_x_zero | i_y_zero;
`endif

    // Scan downwards so the lowest qualifying mode is the one kept.
    always_comb begin
        o_next_mode = MODE_W'(MODE_DC);
        o_last      = 1'b1;
        for (int m = MODE_NUM - 1; m >= 0; m--) begin
            if (m > int'(i_mode) && w_en[m]) begin
                o_next_mode = MODE_W'(m);
                o_last      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/intra_pred_sched.sv
// rtl/intra_pred_sched.sv - macroblock/mode scheduler for an intra predictor
//
// Purpose: walks every macroblock of a frame in raster order and, for each,
// issues the prediction modes in the order DC, TM, VE, HE to the predictor,
// waits for completion and hands the result downstream before moving on.
// Optional feature macro: INTRA_MODE_SKIP_EN (see intra_mode_sel).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   intra_pred_sched_if.slave: start/mb_w/mb_h in, predictor
//         handshake, result handshake, busy and frame_done status
module intra_pred_sched
    import intra_pred_pkg::*;
#(
    parameter int BLOCK_NUM = 10,
    parameter int MODE_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    intra_pred_sched_if.slave     bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BLOCK_NUM-1:0] r_mb_w;
    logic [BLOCK_NUM-1:0] r_mb_h;
    logic [BLOCK_NUM-1:0] r_x;
    logic [BLOCK_NUM-1:0] r_y;
    logic [MODE_W-1:0]    r_mode;

    logic [MODE_W-1:0]    w_next_mode;
    logic                 w_last_mode;
    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_dims_ok;

    assign w_x_last  = (r_x == r_mb_w - BLOCK_NUM'(1));
    assign w_y_last  = (r_y == r_mb_h - BLOCK_NUM'(1));
    assign w_dims_ok = (bus.mb_w != '0) && (bus.mb_h != '0);

    intra_mode_sel #(.MODE_W(MODE_W)) u_mode_sel (
        .i_mode      (r_mode),
        .i_x_zero    (r_x == '0),
        .i_y_zero    (r_y == '0),
        .o_next_mode (w_next_mode),
        .o_last      (w_last_mode)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = w_dims_ok ? ST_ISSUE : ST_FDONE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.pred_done) w_state_nxt = ST_OUT;
            ST_OUT:   if (bus.res_ready) w_state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (!w_last_mode || !(w_x_last && w_y_last)) w_state_nxt = ST_ISSUE;
                else                                         w_state_nxt = ST_FDONE;
            end
            ST_FDONE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Position and mode only move in NEXT, which keeps them stable from
    // ISSUE through OUT. Dimensions are latched once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mb_w  <= '0;
            r_mb_h  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= MODE_W'(MODE_DC);
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mb_w <= bus.mb_w;
                        r_mb_h <= bus.mb_h;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_mode <= MODE_W'(MODE_DC);
                    end
                end
                ST_NEXT: begin
                    if (!w_last_mode) begin
                        r_mode <= w_next_mode;
                    end else if (!(w_x_last && w_y_last)) begin
                        r_mode <= MODE_W'(MODE_DC);
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + BLOCK_NUM'(1);
                        end else begin
                            r_x <= r_x + BLOCK_NUM'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pred_start = (r_state == ST_ISSUE);
    assign bus.res_valid  = (r_state == ST_OUT);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_done = (r_state == ST_FDONE);
    assign bus.pred_x     = r_x;
    assign bus.pred_y     = r_y;
    assign bus.pred_mode  = r_mode;

endmodule

// File: tb/tb_intra_pred_sched.sv
// tb/tb_intra_pred_sched.sv - self-checking bench for intra_pred_sched
module tb_intra_pred_sched;
    import intra_pred_pkg::*;

    localparam int BN = 10;
    localparam int MW = 2;
`ifdef INTRA_MODE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [BN-1:0] x;
        logic [BN-1:0] y;
        logic [MW-1:0] m;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    intra_pred_sched_if #(.BLOCK_NUM(BN), .MODE_W(MW)) bus ();

    intra_pred_sched #(.BLOCK_NUM(BN), .MODE_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    iss_t exp_q[$];
    iss_t lit[$];
    iss_t cur;
    bit   mon_en = 1'b0;
    int   frames = 0;
    int   frames_at_start = 0;
    int   lat = 1;
    bit   abort_armed = 1'b0;
    int   spur_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic iss_t mk(input int x, input int y, input int m);
        iss_t e;
        e.x = BN'(x);
        e.y = BN'(y);
        e.m = MW'(m);
        return e;
    endfunction

    // Mode availability from the neighbour rules; everything is available
    // when skipping is off.
    function automatic bit mode_ok(input int x, input int y, input int m);
        if (!SKIP) return 1'b1;
        case (m)
            1:       return (x != 0) && (y != 0);
            2:       return y != 0;
            3:       return x != 0;
            default: return 1'b1;
        endcase
    endfunction

    // Expected issue order for a whole frame: raster macroblocks, modes ascending.
    function automatic void build(input int w, input int h);
        exp_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                for (int m = 0; m < 4; m++)
                    if (mode_ok(x, y, m)) exp_q.push_back(mk(x, y, m));
    endfunction

    // Predictor model: answers each issue after lat cycles, except the
    // abort-test macroblock; also emits requested spurious completions.
    initial begin
        int spur_seen;
        spur_seen = 0;
        bus.pred_done = 1'b0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_seen) begin
                spur_seen = spur_req;
                bus.pred_done = 1'b1;
                @(negedge clk);
                bus.pred_done = 1'b0;
            end else if (!rst && bus.pred_start && !(abort_armed && bus.pred_x == BN'(1))) begin
                repeat (lat) @(negedge clk);
                bus.pred_done = 1'b1;
                @(negedge clk);
                bus.pred_done = 1'b0;
            end
        end
    end

    // Scoreboard: every issue is matched against the model order, results
    // must carry the issued tuple, and a frame ends only with nothing pending.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (bus.pred_start) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pred_start", 32'd1, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("issue_xym", 32'({bus.pred_x, bus.pred_y, bus.pred_mode}), 32'(cur));
                    end
                end
                if (bus.res_valid)
                    check("hold_xym", 32'({bus.pred_x, bus.pred_y, bus.pred_mode}), 32'(cur));
                if (bus.frame_done) begin
                    check("frame_end_pending", 32'(exp_q.size()), 32'd0);
                    frames++;
                end
            end
        end
    end

    task automatic start_frame(input int w, input int h);
        build(w, h);
        frames_at_start = frames;
        bus.mb_w  = BN'(w);
        bus.mb_h  = BN'(h);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (frames != frames_at_start) seen = 1'b1;
        end
        check({name, "_done"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pred_start"}, 32'(bus.pred_start), 32'd0);
        check({name, "_res_valid"},  32'(bus.res_valid),  32'd0);
        check({name, "_busy"},       32'(bus.busy),       32'd0);
        check({name, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({name, "_pred_x"},     32'(bus.pred_x),     32'd0);
        check({name, "_pred_y"},     32'(bus.pred_y),     32'd0);
        check({name, "_pred_mode"},  32'(bus.pred_mode),  32'd0);
    endtask

    initial begin
        int fw;
        int fh;
        bus.start     = 1'b0;
        bus.mb_w      = '0;
        bus.mb_h      = '0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // Pin the model with hand-written issue lists.
        build(2, 2);
        check("model_2x2_len", 32'(exp_q.size()), SKIP ? 32'd9 : 32'd16);
`ifdef INTRA_MODE_SKIP_EN
        fw = 2; fh = 2;
        lit.push_back(mk(0, 0, 0)); lit.push_back(mk(1, 0, 0)); lit.push_back(mk(1, 0, 3));
        lit.push_back(mk(0, 1, 0)); lit.push_back(mk(0, 1, 2)); lit.push_back(mk(1, 1, 0));
        lit.push_back(mk(1, 1, 1)); lit.push_back(mk(1, 1, 2)); lit.push_back(mk(1, 1, 3));
`else
        fw = 1; fh = 1;
        lit.push_back(mk(0, 0, 0)); lit.push_back(mk(0, 0, 1));
        lit.push_back(mk(0, 0, 2)); lit.push_back(mk(0, 0, 3));
`endif
        build(fw, fh);
        check("model_lit_len", 32'(exp_q.size()), 32'(lit.size()));
        for (int i = 0; i < lit.size() && i < exp_q.size(); i++)
            check("model_lit", 32'(exp_q[i]), 32'(lit[i]));
        exp_q.delete();

        // First frame: start presented on the first edge with rst low.
        rst    = 1'b0;
        mon_en = 1'b1;
        start_frame(fw, fh);
        check("first_pred_start", 32'(bus.pred_start), 32'd1);
        check("first_busy", 32'(bus.busy), 32'd1);
        wait_frame("frame_a");

        // Larger frame; dimension inputs change after start and must not matter.
        lat = 2;
        start_frame(3, 2);
        bus.mb_w = BN'(7);
        bus.mb_h = BN'(1);
        wait_frame("frame_b");

        lat = 3;
        start_frame(2, 3);
        wait_frame("frame_c");

        // Backpressure: result held for 5 cycles, then exactly one advance.
        lat = 1;
        bus.res_ready = 1'b0;
        start_frame(2, 1);
        for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
        check("bp_valid_seen", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(bus.res_valid), 32'd1);
            check("bp_xym_held", 32'({bus.pred_x, bus.pred_y, bus.pred_mode}), 32'(mk(0, 0, 0)));
            if (i == 4) bus.res_ready = 1'b1;
            else        @(negedge clk);
        end
        @(negedge clk);
        check("bp_release", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("bp_one_advance", 32'(bus.pred_start), 32'd1);
        check("bp_next_xym", 32'({bus.pred_x, bus.pred_y, bus.pred_mode}),
              SKIP ? 32'(mk(1, 0, 0)) : 32'(mk(0, 0, 1)));
        wait_frame("frame_bp");

        // Zero dimensions: straight to frame_done, no issue.
        start_frame(0, 3);
        check("zw_frame_done", 32'(bus.frame_done), 32'd1);
        check("zw_pred_start", 32'(bus.pred_start), 32'd0);
        @(negedge clk);
        check("zw_frame_done_end", 32'(bus.frame_done), 32'd0);
        check("zw_idle", 32'(bus.busy), 32'd0);
        start_frame(4, 0);
        check("zh_frame_done", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        check("zh_idle", 32'(bus.busy), 32'd0);

        // start during WAIT must be ignored.
        lat = 4;
        start_frame(2, 1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mb_w  = BN'(5);
        bus.mb_h  = BN'(5);
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'd1);
        check("ign_no_issue", 32'(bus.pred_start), 32'd0);
        check("ign_xym", 32'({bus.pred_x, bus.pred_y, bus.pred_mode}), 32'(mk(0, 0, 0)));
        wait_frame("frame_ign");

        // Mid-frame abort while waiting on macroblock (1,0).
        lat = 1;
        abort_armed = 1'b1;
        start_frame(2, 1);
        for (int i = 0; i < 200 && !(bus.pred_start && bus.pred_x == BN'(1)); i++) @(negedge clk);
        check("abort_reached", 32'(bus.pred_start && bus.pred_x == BN'(1)), 32'd1);
        @(negedge clk);
        check("abort_in_wait", 32'({bus.busy, bus.res_valid}), 32'b10);
        rst    = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        spur_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spur_busy", 32'(bus.busy), 32'd0);
            check("spur_res_valid", 32'(bus.res_valid), 32'd0);
        end
        abort_armed = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;

        // Recovery frame after the abort.
        lat = 2;
        start_frame(2, 2);
        wait_frame("frame_rec");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
